orao_mem_upload: RTL and testbench

Memory-to-HPS upload engine: the read-side counterpart of the ioctl download path that loads images into Orao RAM. While the HPS runs an upload session with the matching index, the block holds the CPU off the memory bus. It serves each HPS byte request from a 4-byte header or from Orao RAM, and returns the byte on `ioctl_din` using `ioctl_wait` flow control. This lets the user save RAM snapshots from the OSD.

---
 rtl/orao_mem_upload.sv | 115 +++++++++++
 tb/tb_orao_mem_upload.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/orao_mem_upload.sv
// Read-side upload engine: serves HPS ioctl byte requests from a 4-byte
// header (base, length) followed by a window of Orao RAM, holding the CPU off the bus.
module orao_mem_upload #(
  parameter logic [15:0] DUMP_BASE    = 16'h0000,
  parameter logic [15:0] DUMP_LEN     = 16'h6000,
  parameter logic [7:0]  UPLOAD_INDEX = 8'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  input  logic [24:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        busy,
  output logic [2:0]  state_dbg
);

  // Handshake: a one-cycle ioctl_rd pulse starts a request and is accepted only
  // in ARMED; ioctl_wait=1 means the byte is not ready, and ioctl_din is valid
  // whenever ioctl_wait=0 after a request has been accepted.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    GNT_WAIT = 3'd2,
    FETCH    = 3'd3,
    CAPTURE  = 3'd4
  } state_t;

  localparam logic [24:0] END_ADDR = 25'd4 + {9'd0, DUMP_LEN};

  state_t      state, state_n;
  logic [7:0]  din_n;
  logic        wait_n;
  logic [15:0] addr_n;
  logic        sel;
  logic [7:0]  hdr_byte;
  logic [15:0] ram_addr;

  assign sel       = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
  assign ram_addr  = DUMP_BASE + ioctl_addr[15:0] - 16'd4;
  assign state_dbg = state;

  always_comb begin
    hdr_byte = 8'h00;
    case (ioctl_addr[1:0])
      2'd0: hdr_byte = DUMP_BASE[7:0];
      2'd1: hdr_byte = DUMP_BASE[15:8];
      2'd2: hdr_byte = DUMP_LEN[7:0];
      2'd3: hdr_byte = DUMP_LEN[15:8];
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    din_n   = ioctl_din;
    wait_n  = ioctl_wait;
    addr_n  = mem_addr;
    if (!sel) begin
      // Abort: drop the request but keep the last delivered byte.
      state_n = IDLE;
      wait_n  = 1'b0;
    end else begin
      case (state)
        IDLE: state_n = ARMED;
        ARMED: begin
          if (ioctl_rd) begin
            if (ioctl_addr < 25'd4) begin
              din_n = hdr_byte;
            end else if (ioctl_addr < END_ADDR) begin
              addr_n  = ram_addr;
              wait_n  = 1'b1;
              state_n = mem_gnt ? FETCH : GNT_WAIT;
            end else begin
              din_n = 8'hFF;
            end
          end
        end
        GNT_WAIT: if (mem_gnt) state_n = FETCH;
        FETCH:    state_n = CAPTURE;
        CAPTURE: begin
          din_n   = mem_data;
          wait_n  = 1'b0;
          state_n = ARMED;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ioctl_din  <= 8'h00;
      ioctl_wait <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_req    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      ioctl_din  <= din_n;
      ioctl_wait <= wait_n;
      mem_addr   <= addr_n;
      mem_req    <= sel;
      busy       <= sel;
    end
  end

endmodule

// File: tb/tb_orao_mem_upload.sv
// Directed bench for orao_mem_upload: one instance with a 0400/16-byte window,
// a second with base FFFF to exercise the 16-bit address wrap.
module tb_orao_mem_upload;

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_GNT_WAIT = 3'd2,
                         S_FETCH = 3'd3, S_CAPTURE = 3'd4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'h00;
  logic        ioctl_rd = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic        mem_gnt = 1'b0;

  logic [7:0]  din_a, din_b, data_a, data_b;
  logic        wait_a, wait_b, req_a, req_b, busy_a, busy_b;
  logic [15:0] addr_a, addr_b;
  logic [2:0]  st_a, st_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  orao_mem_upload #(.DUMP_BASE(16'h0400), .DUMP_LEN(16'h0010), .UPLOAD_INDEX(8'h01)) u_dut (
    .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_a), .ioctl_wait(wait_a),
    .mem_req(req_a), .mem_gnt(mem_gnt), .mem_addr(addr_a), .mem_data(data_a),
    .busy(busy_a), .state_dbg(st_a));

  orao_mem_upload #(.DUMP_BASE(16'hFFFF), .DUMP_LEN(16'h0010), .UPLOAD_INDEX(8'h01)) u_wrap (
    .clk(clk), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
    .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(din_b), .ioctl_wait(wait_b),
    .mem_req(req_b), .mem_gnt(mem_gnt), .mem_addr(addr_b), .mem_data(data_b),
    .busy(busy_b), .state_dbg(st_b));

  // RAM content: 0400 holds A5, everything else is lo ^ hi ^ 3C.
  function automatic logic [7:0] ram_fn(input logic [15:0] a);
    if (a == 16'h0400) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  // Registered RAM: data appears one cycle after the address.
  always @(posedge clk) begin
    data_a <= ram_fn(addr_a);
    data_b <= ram_fn(addr_b);
  end

  // Drivers: inputs change on negedges; after do_rd we sit mid-cycle 1.
  task automatic do_rd(input logic [24:0] a);
    ioctl_rd = 1'b1;
    ioctl_addr = a;
    @(negedge clk);
    ioctl_rd = 1'b0;
  endtask

  task automatic open_session();
    ioctl_index = 8'h01;
    ioctl_upload = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (din_a !== 8'h00) begin failures++; $display("FAIL rst_din got=%h exp=00", din_a); end
    checks++; if (wait_a !== 1'b0) begin failures++; $display("FAIL rst_wait got=%b exp=0", wait_a); end
    checks++; if (req_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL rst_req got=%b%b exp=00", req_a, busy_a); end
    checks++; if (addr_a !== 16'h0000) begin failures++; $display("FAIL rst_addr got=%h exp=0000", addr_a); end
    checks++; if (st_a !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=%0d", st_a, S_IDLE); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_header();
    logic [7:0] exp_a [4];
    logic [7:0] exp_b [4];
    exp_a = '{8'h00, 8'h04, 8'h10, 8'h00};
    exp_b = '{8'hFF, 8'hFF, 8'h10, 8'h00};
    open_session();
    checks++; if (req_a !== 1'b1 || busy_a !== 1'b1) begin failures++; $display("FAIL sess_req got=%b%b exp=11", req_a, busy_a); end
    checks++; if (st_a !== S_ARMED) begin failures++; $display("FAIL sess_state got=%0d exp=%0d", st_a, S_ARMED); end
    for (int i = 0; i < 4; i++) begin
      do_rd(25'(i));
      checks++; if (din_a !== exp_a[i]) begin failures++; $display("FAIL hdr_din a=%0d got=%h exp=%h", i, din_a, exp_a[i]); end
      checks++; if (din_b !== exp_b[i]) begin failures++; $display("FAIL hdr_din_wrap a=%0d got=%h exp=%h", i, din_b, exp_b[i]); end
      checks++; if (wait_a !== 1'b0 || st_a !== S_ARMED) begin failures++; $display("FAIL hdr_wait a=%0d got=%b/%0d exp=0/%0d", i, wait_a, st_a, S_ARMED); end
    end
  endtask

  task automatic test_ram_read();
    mem_gnt = 1'b1;
    do_rd(25'd4);
    checks++; if (wait_a !== 1'b1 || st_a !== S_FETCH) begin failures++; $display("FAIL ram_c1 got=%b/%0d exp=1/%0d", wait_a, st_a, S_FETCH); end
    checks++; if (addr_a !== 16'h0400) begin failures++; $display("FAIL ram_addr got=%h exp=0400", addr_a); end
    checks++; if (addr_b !== 16'hFFFF) begin failures++; $display("FAIL ram_addr_wrap got=%h exp=ffff", addr_b); end
    @(negedge clk);
    checks++; if (wait_a !== 1'b1 || st_a !== S_CAPTURE) begin failures++; $display("FAIL ram_c2 got=%b/%0d exp=1/%0d", wait_a, st_a, S_CAPTURE); end
    @(negedge clk);
    checks++; if (wait_a !== 1'b0 || st_a !== S_ARMED) begin failures++; $display("FAIL ram_c3 got=%b/%0d exp=0/%0d", wait_a, st_a, S_ARMED); end
    checks++; if (din_a !== 8'hA5) begin failures++; $display("FAIL ram_din got=%h exp=a5", din_a); end
    checks++; if (din_b !== 8'h3C) begin failures++; $display("FAIL ram_din_wrap got=%h exp=3c", din_b); end
  endtask

  task automatic test_delayed_grant();
    int cnt = 0;
    mem_gnt = 1'b0;
    do_rd(25'd5);
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (wait_a === 1'b1) cnt++;
      ioctl_rd = 1'b0;
      if (cyc == 2) begin
        ioctl_rd = 1'b1;   // stray request while one is in flight
        ioctl_addr = 25'd0;
      end
      if (cyc == 5) mem_gnt = 1'b1;
      if (wait_a !== 1'b1) break;
      @(negedge clk);
    end
    ioctl_rd = 1'b0;
    checks++; if (cnt != 7) begin failures++; $display("FAIL dly_wait_cycles got=%0d exp=7", cnt); end
    checks++; if (din_a !== 8'h39) begin failures++; $display("FAIL dly_din got=%h exp=39", din_a); end
    checks++; if (addr_a !== 16'h0401) begin failures++; $display("FAIL dly_addr got=%h exp=0401", addr_a); end
    checks++; if (addr_b !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h exp=0000", addr_b); end
    checks++; if (din_b !== 8'h3C) begin failures++; $display("FAIL wrap_din got=%h exp=3c", din_b); end
  endtask

  task automatic test_bounds_wrap();
    mem_gnt = 1'b1;
    do_rd(25'd19);
    @(negedge clk);
    @(negedge clk);
    checks++; if (din_a !== 8'h37 || addr_a !== 16'h040F) begin failures++; $display("FAIL last_byte got=%h@%h exp=37@040f", din_a, addr_a); end
    checks++; if (din_b !== 8'h32 || addr_b !== 16'h000E) begin failures++; $display("FAIL last_byte_wrap got=%h@%h exp=32@000e", din_b, addr_b); end
    do_rd(25'd20);
    checks++; if (din_a !== 8'hFF || din_b !== 8'hFF) begin failures++; $display("FAIL oob_din got=%h/%h exp=ff/ff", din_a, din_b); end
    checks++; if (wait_a !== 1'b0 || st_a !== S_ARMED) begin failures++; $display("FAIL oob_wait got=%b/%0d exp=0/%0d", wait_a, st_a, S_ARMED); end
    checks++; if (addr_a !== 16'h040F) begin failures++; $display("FAIL oob_addr got=%h exp=040f", addr_a); end
    do_rd(25'h0010004);
    checks++; if (din_a !== 8'hFF || wait_a !== 1'b0 || st_a !== S_ARMED) begin failures++; $display("FAIL oob25 got=%h/%b/%0d exp=ff/0/%0d", din_a, wait_a, st_a, S_ARMED); end
    checks++; if (addr_a !== 16'h040F) begin failures++; $display("FAIL oob25_addr got=%h exp=040f", addr_a); end
  endtask

  task automatic test_index_abort();
    ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (req_a !== 1'b0 || busy_a !== 1'b0 || st_a !== S_IDLE) begin failures++; $display("FAIL close got=%b%b/%0d exp=00/%0d", req_a, busy_a, st_a, S_IDLE); end
    ioctl_index = 8'h00;
    ioctl_upload = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_a !== 1'b0 || st_a !== S_IDLE) begin failures++; $display("FAIL bad_idx got=%b/%0d exp=0/%0d", req_a, st_a, S_IDLE); end
    do_rd(25'd2);
    checks++; if (din_a !== 8'hFF || wait_a !== 1'b0) begin failures++; $display("FAIL bad_idx_rd got=%h/%b exp=ff/0", din_a, wait_a); end
    ioctl_upload = 1'b0;
    @(negedge clk);
    open_session();
    mem_gnt = 1'b0;
    do_rd(25'd6);
    checks++; if (st_a !== S_GNT_WAIT || wait_a !== 1'b1) begin failures++; $display("FAIL gnt_wait got=%0d/%b exp=%0d/1", st_a, wait_a, S_GNT_WAIT); end
    @(negedge clk);
    ioctl_upload = 1'b0;
    @(negedge clk);
    checks++; if (wait_a !== 1'b0 || req_a !== 1'b0 || st_a !== S_IDLE) begin failures++; $display("FAIL abort got=%b%b/%0d exp=00/%0d", wait_a, req_a, st_a, S_IDLE); end
    checks++; if (din_a !== 8'hFF) begin failures++; $display("FAIL abort_din got=%h exp=ff", din_a); end
  endtask

  task automatic test_reset_mid_fetch();
    open_session();
    mem_gnt = 1'b1;
    do_rd(25'd4);
    checks++; if (st_a !== S_FETCH) begin failures++; $display("FAIL pre_rst got=%0d exp=%0d", st_a, S_FETCH); end
    #1 reset = 1'b0;
    #1;
    checks++; if (din_a !== 8'h00 || wait_a !== 1'b0 || req_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL async_rst got=%h/%b%b%b exp=00/000", din_a, wait_a, req_a, busy_a); end
    checks++; if (addr_a !== 16'h0000 || st_a !== S_IDLE) begin failures++; $display("FAIL async_rst_st got=%h/%0d exp=0000/%0d", addr_a, st_a, S_IDLE); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (req_a !== 1'b1 || st_a !== S_ARMED) begin failures++; $display("FAIL post_rst got=%b/%0d exp=1/%0d", req_a, st_a, S_ARMED); end
    do_rd(25'd2);
    checks++; if (din_a !== 8'h10) begin failures++; $display("FAIL post_rst_hdr got=%h exp=10", din_a); end
    do_rd(25'd4);
    @(negedge clk);
    @(negedge clk);
    checks++; if (din_a !== 8'hA5 || wait_a !== 1'b0) begin failures++; $display("FAIL post_rst_ram got=%h/%b exp=a5/0", din_a, wait_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_header();
    test_ram_read();
    test_delayed_grant();
    test_bounds_wrap();
    test_index_abort();
    test_reset_mid_fetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
